param_universal_shift_register: RTL and testbench
=================================================

Name: param_universal_shift_register

Overview:
Parametrised successor to the team's 4-bit universal shift register. WIDTH-bit register with parallel load, logical shifts, rotates and arithmetic right shift. A single command performs a multi-step shift of 1..2^AMT_W-1 positions, one position per clock, using a start/busy/done handshake and a pause enable. It drives board LEDs, feeds serial links and stages data for downstream datapath blocks.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AMT_W, 4, width of shift-amount field; derived default is $clog2(WIDTH)+1

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
en  in  1  advance enable; when 0 the FSM, counter and q all freeze
start  in  1  command strobe, accepted only in IDLE with en=1
mode  in  3  operation, encodings below
amt  in  AMT_W  number of single-position steps for shift/rotate modes
load_data  in  WIDTH  parallel load value
sin_lsb  in  1  serial bit entering bit 0 on a left shift
sin_msb  in  1  serial bit entering bit WIDTH-1 on a right shift
q  out  WIDTH  register contents
ser_out_msb  out  1  q[WIDTH-1], combinational from q
ser_out_lsb  out  1  q[0], combinational from q
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse when a command completes

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RST_N). Reset: q=0, state=IDLE, cnt=0, busy=0, done=0.
- Modes:
  - 000 LOAD: q<=load_data.
  - 001 SHL: q<={q[W-2:0],sin_lsb}.
  - 010 SHR: q<={sin_msb,q[W-1:1]}.
  - 011 ROL: q<={q[W-2:0],q[W-1]}.
  - 100 ROR: q<={q[0],q[W-1:1]}.
  - 101 ASR: q<={q[W-1],q[W-1:1]}.
  - 110 and 111 NOP: q unchanged. These complete like amt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1 and en=1, latch mode into op_r.
  - LOAD: q loads on that edge; go to DONE. amt is ignored.
  - NOP, or amt=0 for any shift/rotate mode: q unchanged; go to DONE.
  - amt=N>=1: the first step executes on the start edge.
    - N=1: go to DONE.
    - N>1: cnt<=N-1; go to RUN.
- RUN: each edge with en=1 executes one step of op_r and decrements cnt. When cnt==1, execute the final step and go to DONE.
- DONE: done=1 for exactly one en-qualified cycle; next edge with en=1 goes to IDLE.
- Latency: for N>=1, q holds the final value after N edges counted from the start edge. done rises the cycle after the final step. Back-to-back commands are accepted every N+1 cycles minimum.
- mode and amt are sampled only at accept. Changes during RUN are ignored.
- sin_lsb and sin_msb are sampled live on every step edge.
- start while busy=1 (RUN or DONE) is ignored and not queued.
- en=0 in any state: everything holds, including done. done therefore stays high until the en-qualified cycle completes.
- RST_N asserted mid-RUN: immediate clear to reset values; the command is dropped with no done.
- Boundary cases:
  - amt greater than WIDTH is legal. Rotates wrap fully; shifts fully flush q with serial bits.
  - amt all-ones is the maximum step count.

Decomposition:
- Package usr_pkg:
  - mode encodings (MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR)
  - FSM state encodings
  - function for the default AMT_W from WIDTH
- Sub-module usr_step_unit: combinational next-value for one step.
  - Inputs: q, op, sin_lsb, sin_msb, load_data.
  - Output: q_next.
  - Parametrised by WIDTH.
- The top level holds the FSM, counter and register.

Test Plan:
- Reset mid-RUN: after RST_N low, q=0, busy=0, done=0. After release, IDLE accepts a new command.
- LOAD 8'hA5 with start=1 -> q=8'hA5 after 1 edge; done pulses on the next cycle; busy high for exactly 1 cycle.
- q=8'h81, ROL amt=3 -> q=8'h0C after 3 edges; done 1 cycle later. ROR amt=8 from 8'h3C -> q=8'h3C.
- q=8'h90, ASR amt=2 -> 8'hE4. SHR amt=2 with sin_msb=0 -> 8'h24. SHL amt=4 with sin_lsb toggling 1,0,1,1 from 8'h00 -> 8'h0B.
- en held low for 3 cycles mid-RUN: q, cnt and busy frozen. start pulsed while busy is ignored. Final value and done timing are shifted by exactly 3 cycles.
- amt=0 SHL and mode=110: q unchanged, done pulses 1 cycle after start. amt=15 SHL with sin_lsb=1 -> q=8'hFF, done after 15 edges.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings and helpers for the parametrised universal shift register.
// Mode and state encodings live here so the step unit and the FSM agree on them.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_LOAD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ASR  = 3'b101,
        MODE_NOP0 = 3'b110,
        MODE_NOP1 = 3'b111
    } usr_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } usr_state_e;

    // Enough bits to express a full flush of WIDTH positions.
    function automatic int usr_default_amt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    // Modes that walk the register one position per step.
    function automatic logic usr_is_stepped(input usr_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_step_unit.sv
// Combinational next value of the register for a single step of one operation.
module usr_step_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  usr_mode_e        op,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            MODE_LOAD: q_next = load_data;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_lsb};
            MODE_SHR:  q_next = {sin_msb, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register: one command runs 1..2^AMT_W-1 single-position
// steps, one per enabled clock, with a start/busy/done handshake.
module param_universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = usr_default_amt_w(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    usr_state_e       state, state_n;
    usr_mode_e        op_r, op_n, op_sel, mode_in;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] q_n, q_step;

    assign mode_in = usr_mode_e'(mode);
    // The first step runs on the accept edge, before op_r holds the new mode.
    assign op_sel  = (state == ST_IDLE) ? mode_in : op_r;

    usr_step_unit #(.WIDTH(WIDTH)) u_step (
        .q         (q),
        .op        (op_sel),
        .sin_lsb   (sin_lsb),
        .sin_msb   (sin_msb),
        .load_data (load_data),
        .q_next    (q_step)
    );

    always_comb begin
        state_n = state;
        op_n    = op_r;
        cnt_n   = cnt;
        q_n     = q;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_n    = mode_in;
                        state_n = ST_DONE;
                        if (mode_in == MODE_LOAD) begin
                            q_n = q_step;
                        end else if (usr_is_stepped(mode_in) && amt != '0) begin
                            q_n = q_step;
                            if (amt != AMT_W'(1)) begin
                                cnt_n   = amt - AMT_W'(1);
                                state_n = ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    q_n   = q_step;
                    cnt_n = cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) state_n = ST_DONE;
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            op_r  <= MODE_LOAD;
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_n;
            op_r  <= op_n;
            cnt   <= cnt_n;
            q     <= q_n;
        end
    end

    // done is state-decoded so it naturally holds while en is low.
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign ser_out_msb = q[WIDTH-1];
    assign ser_out_lsb = q[0];

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for param_universal_shift_register at WIDTH=8, AMT_W=4.
module tb_param_universal_shift_register;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       en, start, sin_lsb, sin_msb;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] load_data;
    logic [7:0] q;
    logic       ser_out_msb, ser_out_lsb, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    param_universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .en(en), .start(start), .mode(mode), .amt(amt),
        .load_data(load_data), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q),
        .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] init;
        logic [2:0] mode;
        logic [3:0] amt;
        logic       lsb;
        logic       msb;
        logic [7:0] ld;
        logic [7:0] exp_q;
        int         exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one command and count edges from the accept edge until done is seen.
    task automatic cmd(input logic [2:0] m, input logic [3:0] a, output int lat);
        mode  = m;
        amt   = a;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        int lat;
        vecs[0]  = '{8'h00, 3'b000, 4'd0,  1'b0, 1'b0, 8'hA5, 8'hA5, 1};
        vecs[1]  = '{8'h81, 3'b011, 4'd3,  1'b0, 1'b0, 8'h00, 8'h0C, 3};
        vecs[2]  = '{8'h3C, 3'b100, 4'd8,  1'b0, 1'b0, 8'h00, 8'h3C, 8};
        vecs[3]  = '{8'h90, 3'b101, 4'd2,  1'b0, 1'b0, 8'h00, 8'hE4, 2};
        vecs[4]  = '{8'h90, 3'b010, 4'd2,  1'b0, 1'b0, 8'h00, 8'h24, 2};
        vecs[5]  = '{8'h5A, 3'b001, 4'd0,  1'b1, 1'b1, 8'h00, 8'h5A, 1};
        vecs[6]  = '{8'h5A, 3'b110, 4'd5,  1'b1, 1'b1, 8'h00, 8'h5A, 1};
        vecs[7]  = '{8'h00, 3'b001, 4'd15, 1'b1, 1'b0, 8'h00, 8'hFF, 15};
        vecs[8]  = '{8'h00, 3'b010, 4'd9,  1'b0, 1'b1, 8'h00, 8'hFF, 9};
        vecs[9]  = '{8'h81, 3'b011, 4'd9,  1'b0, 1'b0, 8'h00, 8'h03, 9};
        vecs[10] = '{8'h70, 3'b101, 4'd3,  1'b1, 1'b1, 8'h00, 8'h0E, 3};
        vecs[11] = '{8'hC3, 3'b111, 4'd3,  1'b1, 1'b1, 8'h00, 8'hC3, 1};
        vecs[12] = '{8'h80, 3'b001, 4'd1,  1'b1, 1'b0, 8'h00, 8'h01, 1};
        vecs[13] = '{8'h01, 3'b100, 4'd1,  1'b0, 1'b0, 8'h00, 8'h80, 1};

        RST_N = 1'b0; en = 1'b1; start = 1'b0; mode = 3'b000; amt = 4'd0;
        load_data = 8'h00; sin_lsb = 1'b0; sin_msb = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_q", 32'(q), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        foreach (vecs[i]) begin
            load_data = vecs[i].init;
            cmd(3'b000, 4'd0, lat);
            sin_lsb   = vecs[i].lsb;
            sin_msb   = vecs[i].msb;
            load_data = vecs[i].ld;
            cmd(vecs[i].mode, vecs[i].amt, lat);
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // LOAD: busy and done for exactly one cycle after the accept edge.
        load_data = 8'hA5; mode = 3'b000; amt = 4'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("load_q", 32'(q), 32'hA5);
        chk("load_busy1", 32'(busy), 32'h1);
        chk("load_done1", 32'(done), 32'h1);
        @(posedge CLK); #1;
        chk("load_busy2", 32'(busy), 32'h0);
        chk("load_done2", 32'(done), 32'h0);

        // SHL by 4 with sin_lsb sampled live: 1,0,1,1.
        load_data = 8'h00;
        cmd(3'b000, 4'd0, lat);
        mode = 3'b001; amt = 4'd4; sin_lsb = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; sin_lsb = 1'b0;
        @(posedge CLK); #1;
        sin_lsb = 1'b1;
        @(posedge CLK); #1;
        mode = 3'b000; amt = 4'd0;
        @(posedge CLK); #1;
        chk("shl_live_q", 32'(q), 32'h0B);
        chk("shl_live_done", 32'(done), 32'h1);
        @(posedge CLK); #1;

        // en low for 3 cycles mid-RUN, with start strobes while busy.
        load_data = 8'h81;
        cmd(3'b000, 4'd0, lat);
        mode = 3'b011; amt = 4'd3; start = 1'b1;
        @(posedge CLK); #1;
        chk("freeze_step1", 32'(q), 32'h03);
        en = 1'b0; mode = 3'b000; load_data = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        chk("freeze_q", 32'(q), 32'h03);
        chk("freeze_busy", 32'(busy), 32'h1);
        en = 1'b1;
        @(posedge CLK); #1;
        chk("resume_step2", 32'(q), 32'h06);
        chk("resume_done_early", 32'(done), 32'h0);
        @(posedge CLK); #1;
        chk("resume_q", 32'(q), 32'h0C);
        chk("resume_done", 32'(done), 32'h1);
        en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("done_hold", 32'(done), 32'h1);
        en = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("busy_start_ignored_q", 32'(q), 32'h0C);
        chk("busy_start_ignored_done", 32'(done), 32'h0);
        chk("busy_start_ignored_busy", 32'(busy), 32'h0);

        // Reset asserted mid-RUN drops the command.
        load_data = 8'hFF;
        cmd(3'b000, 4'd0, lat);
        mode = 3'b010; amt = 4'd10; sin_msb = 1'b0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #2;
        chk("midrun_rst_q", 32'(q), 32'h00);
        chk("midrun_rst_busy", 32'(busy), 32'h0);
        chk("midrun_rst_done", 32'(done), 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_idle_done", 32'(done), 32'h0);
        load_data = 8'h5A;
        cmd(3'b000, 4'd0, lat);
        chk("post_rst_q", 32'(q), 32'h5A);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("ser_msb", 32'(ser_out_msb), 32'h0);
        chk("ser_lsb", 32'(ser_out_lsb), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
